// File: rtl/ni_vc_tx.sv
// rtl/ni_vc_tx.sv - clocked NI transmitter: valid/ready flits to 4-phase 1-of-4 QDI link with per-VC credits
// Rails change only on the accept edge or the return-to-zero edge, so the router never sees a partial codeword.

module ni_vc_tx #(
  parameter int DW  = 32,
  parameter int VCN = 2,
  parameter int SCN = DW / 2,
  parameter int FT  = 3,
  parameter int CD  = 4,
  parameter int CW  = 3,
  parameter int SYN = 2
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [DW-1:0]      i_in_data,
  input  logic [FT-1:0]      i_in_ft,
  input  logic [VCN-1:0]     i_in_vc,
  output logic [SCN-1:0]     o_do0,
  output logic [SCN-1:0]     o_do1,
  output logic [SCN-1:0]     o_do2,
  output logic [SCN-1:0]     o_do3,
  output logic [FT-1:0]      o_dot,
  output logic [VCN-1:0]     o_dovc,
  input  logic               i_doa,
  input  logic [VCN-1:0]     i_cor,
  output logic [VCN-1:0]     o_coa,
  output logic [VCN*CW-1:0]  o_crd
);

  typedef enum logic [1:0] {IDLE, SEND, RTZ} state_t;

  localparam logic [CW-1:0] LP_CD  = CW'(CD);
  localparam logic [CW-1:0] LP_ONE = CW'(1);

  state_t           r_state;
  logic [SYN-1:0]   r_doa_sync;
  logic [VCN-1:0]   r_cor_sync [SYN];
  logic [SCN-1:0]   r_do [4];
  logic [FT-1:0]    r_dot;
  logic [VCN-1:0]   r_dovc;
  logic [VCN-1:0]   r_coa;
  logic [CW-1:0]    r_crd [VCN];

  logic             w_doa_s;
  logic [VCN-1:0]   w_cor_s;
  logic [VCN-1:0]   w_crd_nz;
  logic [VCN-1:0]   w_inc;
  logic [VCN-1:0]   w_dec;
  logic             w_vc_ok;
  logic             w_ft_ok;
  logic             w_in_ready;
  logic             w_accept;
  logic [SCN-1:0]   w_enc [4];

  assign w_doa_s = r_doa_sync[SYN-1];
  assign w_cor_s = r_cor_sync[SYN-1];

  assign w_vc_ok = (i_in_vc != '0) && ((i_in_vc & (i_in_vc - 1'b1)) == '0);
  assign w_ft_ok = (i_in_ft != '0) && ((i_in_ft & (i_in_ft - 1'b1)) == '0);

  always_comb begin
    w_crd_nz = '0;
    for (int v = 0; v < VCN; v++) w_crd_nz[v] = (r_crd[v] != '0);
  end

  // Ready is a function of state, synchronized ack, credits and the requested VC/type only.
  assign w_in_ready = i_rstn && (r_state == IDLE) && !w_doa_s && w_vc_ok && w_ft_ok
                      && ((i_in_vc & w_crd_nz) != '0);
  assign w_accept   = i_in_valid && w_in_ready;
  assign w_dec      = w_accept ? i_in_vc : '0;
  assign w_inc      = w_cor_s & ~r_coa;

  always_comb begin
    for (int r = 0; r < 4; r++) w_enc[r] = '0;
    for (int i = 0; i < SCN; i++) w_enc[i_in_data[2*i +: 2]][i] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_doa_sync <= '0;
      for (int k = 0; k < SYN; k++) r_cor_sync[k] <= '0;
    end else begin
      r_doa_sync <= {r_doa_sync[SYN-2:0], i_doa};
      r_cor_sync[0] <= i_cor;
      for (int k = 1; k < SYN; k++) r_cor_sync[k] <= r_cor_sync[k-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= IDLE;
      for (int r = 0; r < 4; r++) r_do[r] <= '0;
      r_dot  <= '0;
      r_dovc <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            assert (w_vc_ok && w_ft_ok)
              else $warning("ni_vc_tx: in_vc or in_ft not one-hot while in_valid");
          end
          if (w_accept) begin
            for (int r = 0; r < 4; r++) r_do[r] <= w_enc[r];
            r_dot   <= i_in_ft;
            r_dovc  <= i_in_vc;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_doa_s) begin
            for (int r = 0; r < 4; r++) r_do[r] <= '0;
            r_dot   <= '0;
            r_dovc  <= '0;
            r_state <= RTZ;
          end
        end
        RTZ: begin
          if (!w_doa_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // coa simply follows the synchronized request; the rising edge of that pair is the one credit.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_coa <= '0;
      for (int v = 0; v < VCN; v++) r_crd[v] <= LP_CD;
    end else begin
      r_coa <= w_cor_s;
      for (int v = 0; v < VCN; v++) begin
        if (w_inc[v] && !w_dec[v]) begin
          assert (r_crd[v] != LP_CD)
            else $warning("ni_vc_tx: credit return beyond depth on vc %0d", v);
          if (r_crd[v] != LP_CD) r_crd[v] <= r_crd[v] + LP_ONE;
        end else if (w_dec[v] && !w_inc[v]) begin
          r_crd[v] <= r_crd[v] - LP_ONE;
        end
      end
    end
  end

  genvar gv;
  generate
    for (gv = 0; gv < VCN; gv++) begin : g_crd
      assign o_crd[gv*CW +: CW] = r_crd[gv];
    end
  endgenerate

  assign o_in_ready = w_in_ready;
  assign o_do0      = r_do[0];
  assign o_do1      = r_do[1];
  assign o_do2      = r_do[2];
  assign o_do3      = r_do[3];
  assign o_dot      = r_dot;
  assign o_dovc     = r_dovc;
  assign o_coa      = r_coa;

endmodule
